// File: rtl/tron_score_keeper.sv
// tron_score_keeper: per-player round wins and match winner for the two-player Tron match.
// Ports:
//   board_clk  100 MHz system clock
//   Reset      asynchronous active-high reset
//   start      begin-match pulse, honoured in IDLE
//   ack        match-acknowledge pulse, honoured in OVER
//   round_end  round finished; p1_crash/p2_crash valid with it
//   p1_score   P1 wins for SSD4 (4'hF = blanked)
//   p2_score   P2 wins for SSD0 (4'hF = blanked)
//   playing    high in PLAY
//   match_over high in OVER
//   winner     00 none, 01 P1, 10 P2
//   round_draw one-cycle pulse after a round where both crashed
// Optional feature: define TRON_SCORE_BLINK_EN to blink the winner's digit in OVER
// at the rate set by counter bit BLINK_BIT.
module tron_score_keeper #(
  parameter int WIN_SCORE = 5,
  parameter int BLINK_BIT = 24
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       ack,
  input  logic       round_end,
  input  logic       p1_crash,
  input  logic       p2_crash,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       playing,
  output logic       match_over,
  output logic [1:0] winner,
  output logic       round_draw
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t     state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic       draw_q, draw_d;
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= '0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    draw_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = PLAY;
        p1_d     = '0;
        p2_d     = '0;
        winner_d = '0;
      end
      PLAY: if (round_end) begin
        if (p2_crash && !p1_crash) begin
          p1_d = p1_q + 4'd1;
          if (p1_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end
        end else if (p1_crash && !p2_crash) begin
          p2_d = p2_q + 4'd1;
          if (p2_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end
        end else if (p1_crash && p2_crash) begin
          draw_d = 1'b1;
        end
      end
      OVER: if (ack) begin
        state_d  = IDLE;
        p1_d     = '0;
        p2_d     = '0;
        winner_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign playing    = state_q == PLAY;
  assign match_over = state_q == OVER;
  assign winner     = winner_q;
  assign round_draw = draw_q;
`ifdef TRON_SCORE_BLINK_EN
  logic [BLINK_BIT:0] ctr_q, ctr_d;
  logic               blank;
  assign ctr_d = ctr_q + {{BLINK_BIT{1'b0}}, 1'b1};
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) ctr_q <= '0;
    else ctr_q <= ctr_d;
  end
  assign blank    = (state_q == OVER) && ctr_q[BLINK_BIT];
  assign p1_score = (blank && winner_q == 2'b01) ? 4'hF : p1_q;
  assign p2_score = (blank && winner_q == 2'b10) ? 4'hF : p2_q;
`else
  logic unused_blink;
  assign unused_blink = |BLINK_BIT;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
`endif
endmodule
